kmkz_ahb_arbiter: RTL and testbench
===================================

KMKZ_AHB_ARBITER -- requirements
Module: kmkz_ahb_arbiter

Interface
REQ-001 The block SHALL provide parameter STARVE_MAX, default 4, as the maximum number of consecutive M1 grants allowed while M0 is requesting.
REQ-002 The block SHALL provide port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL provide port rst_i, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL provide ports mN_haddr_i, input, 32, address of master N (N=0 instruction fetch, N=1 load/store).
REQ-005 The block SHALL provide ports mN_htrans_i, input, 2, transfer type of master N; bit 1 set means request.
REQ-006 The block SHALL provide ports mN_hsize_i (3) and mN_hprot_i (4), input, attributes of master N.
REQ-007 The block SHALL provide ports m1_hwrite_i (1) and m1_hwdata_i (32), input, write control and data of M1; M0 is read-only.
REQ-008 The block SHALL provide ports mN_hready_o, output, 1, transfer-done/address-accepted indication to master N.
REQ-009 The block SHALL provide ports mN_hrdata_o (32) and mN_hresp_o (1), output, read data and error response to master N.
REQ-010 The block SHALL provide slave-side outputs HADDR (32), HTRANS (2), HWRITE (1), HSIZE (3), HPROT (4), HWDATA (32).
REQ-011 The block SHALL provide slave-side inputs HRDATA (32), HREADY (1), HRESP (1).
REQ-012 The block SHALL provide output hmaster_o, 1, the current data-phase owner.

Function
REQ-013 Address-phase grant SHALL be combinational: M1 if requesting, unless the starvation counter equals STARVE_MAX and M0 is requesting, in which case M0.
REQ-014 HADDR/HTRANS/HWRITE/HSIZE/HPROT SHALL mux from the granted master; with no requester, HTRANS SHALL be 2'b00 and HWRITE 0.
REQ-015 M0 grants SHALL drive HWRITE 0.
REQ-016 hmaster_o, the data-phase owner register, SHALL load the grant index, together with a data-phase-valid flag, only on a cycle with HREADY=1.
REQ-017 HWDATA SHALL be m1_hwdata_i when the data-phase owner is M1, else 0.
REQ-018 The starvation counter (3 bits) SHALL increment on each accepted M1 grant while M0 requests.
REQ-019 The starvation counter SHALL clear on each accepted M0 grant or whenever M0 is not requesting.
REQ-020 The starvation counter SHALL saturate at STARVE_MAX.
REQ-021 For a requesting master that is not granted, mN_hready_o SHALL be 0.
REQ-022 If that non-granted master also owns the current data phase and HREADY=1, HRDATA/HRESP SHALL be captured into its hold register and a hold-valid flag set.
REQ-023 When a master with hold-valid set is granted and HREADY=1, mN_hready_o SHALL be 1 with mN_hrdata_o/mN_hresp_o taken from the hold register; hold-valid SHALL then clear.
REQ-024 Otherwise mN_hready_o SHALL equal HREADY, and mN_hrdata_o/mN_hresp_o SHALL pass HRDATA/HRESP when N owns the data phase, else 0.
REQ-025 An idle (non-requesting) master SHALL see mN_hready_o = HREADY.
REQ-026 Grant SHALL NOT change while HREADY=0; the granted master is latched on HREADY low and held until HREADY returns high.
REQ-027 An error response (HRESP=1) SHALL be forwarded to the data-phase owner for both cycles, or captured per REQ-022.
REQ-028 Throughput SHALL be one transfer per cycle; the block SHALL add zero latency for an uncontended master.

Reset
REQ-029 While rst_i=1: hmaster_o=0, data-phase-valid=0, both hold-valid flags=0, hold registers=0, starvation counter=0, latched grant=M0.
REQ-030 Reset SHALL take effect immediately and abandon any in-flight transfer; after release, a transfer in the slave data phase SHALL be ignored, and the first grant SHALL follow REQ-013 from the cleared state.

Verification
REQ-031 Only M0 requests continuously, HREADY=1, HRDATA=address -> m0_hready_o=1 every cycle; m0_hrdata_o tracks HRDATA one cycle after each address.
REQ-032 M0 and M1 both request every cycle, STARVE_MAX=4 -> grant pattern M1,M1,M1,M1,M0 repeating; no M0 gap exceeds 4 cycles.
REQ-033 M0 read at 0x100 is in its data phase when M1 takes the bus, HRDATA=0xDEADBEEF -> value held; m0_hready_o=0 until M0 is regranted, then 1 with m0_hrdata_o=0xDEADBEEF.
REQ-034 M1 write to 0x2000 with data 0x12345678, HREADY low 3 cycles -> HADDR/grant stable, HWDATA=0x12345678 throughout, m1_hready_o low 3 cycles.
REQ-035 HRESP=1 for 2 cycles on M1 data phase -> m1_hresp_o=1 both cycles, m0_hresp_o=0.
REQ-036 rst_i pulsed mid-transfer with hold-valid set -> all outputs, hold flags and counter return to REQ-029 values within the same cycle.

Source files
------------

// File: rtl/kmkz_ahb_arbiter.sv
// -----------------------------------------------------------------------------
// kmkz_ahb_arbiter
//   Two-master AHB-lite arbiter. M0 is the instruction-fetch port and is
//   read-only. M1 is the load/store port. M1 wins arbitration unless it has
//   already taken STARVE_MAX accepted grants in a row while M0 was waiting.
//   A master that loses the bus while its previous read is still in the slave
//   data phase has that response parked in a hold register. The response is
//   handed back when the master is next granted.
//
// Handshake: mN_htrans_i[1] is the request (valid). A master's address is
//   accepted, and its previous data phase completes, on a rising edge where
//   mN_hready_o=1. The slave side follows plain AHB-lite, and HREADY is the
//   ready signal for both the address and data phases.
//
// Ports
//   clk_i, rst_i                     clock, async active-high reset
//   mN_haddr/htrans/hsize/hprot_i    master N address-phase attributes
//   m1_hwrite_i, m1_hwdata_i         M1 write control and write data
//   mN_hready_o/hrdata_o/hresp_o     per-master completion, read data, error
//   HADDR..HWDATA                    slave-side address/data phase outputs
//   HRDATA, HREADY, HRESP            slave-side response inputs
//   hmaster_o                        owner of the current data phase
// -----------------------------------------------------------------------------
module kmkz_ahb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_haddr_i,
  input  logic [1:0]  m0_htrans_i,
  input  logic [2:0]  m0_hsize_i,
  input  logic [3:0]  m0_hprot_i,
  input  logic [31:0] m1_haddr_i,
  input  logic [1:0]  m1_htrans_i,
  input  logic [2:0]  m1_hsize_i,
  input  logic [3:0]  m1_hprot_i,
  input  logic        m1_hwrite_i,
  input  logic [31:0] m1_hwdata_i,
  output logic        m0_hready_o,
  output logic [31:0] m0_hrdata_o,
  output logic        m0_hresp_o,
  output logic        m1_hready_o,
  output logic [31:0] m1_hrdata_o,
  output logic        m1_hresp_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        hmaster_o
);

  localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);

  logic        w_m0_req, w_m1_req;
  logic        w_starved, w_raw_gnt, w_gnt, w_gnt_req;
  logic        w_m0_own, w_m1_own;
  logic        r_gnt_lat, r_wait;
  logic        r_hmaster, r_dp_valid;
  logic [2:0]  r_starve;
  logic        r_m0_hold_vld, r_m1_hold_vld;
  logic [31:0] r_m0_hold_data, r_m1_hold_data;
  logic        r_m0_hold_resp, r_m1_hold_resp;

  assign w_m0_req = m0_htrans_i[1];
  assign w_m1_req = m1_htrans_i[1];

  // Grant index: 1 = M1, 0 = M0. With no requester the index defaults to M0.
  assign w_starved = (r_starve == LP_STARVE_MAX) && w_m0_req;
  assign w_raw_gnt = w_m1_req && !w_starved;
  // Once HREADY has been seen low, keep presenting the grant that was on the
  // bus then until the stalled address is finally accepted.
  assign w_gnt     = r_wait ? r_gnt_lat : w_raw_gnt;
  assign w_gnt_req = w_gnt ? w_m1_req : w_m0_req;

  assign w_m0_own  = r_dp_valid && !r_hmaster;
  assign w_m1_own  = r_dp_valid &&  r_hmaster;

  // Address-phase mux
  always_comb begin
    HADDR  = w_gnt ? m1_haddr_i : m0_haddr_i;
    HSIZE  = w_gnt ? m1_hsize_i : m0_hsize_i;
    HPROT  = w_gnt ? m1_hprot_i : m0_hprot_i;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    if (w_gnt_req) begin
      HTRANS = w_gnt ? m1_htrans_i : m0_htrans_i;
      HWRITE = w_gnt && m1_hwrite_i;
    end
  end

  assign HWDATA    = r_hmaster ? m1_hwdata_i : 32'h0;
  assign hmaster_o = r_hmaster;

  // Per-master response path
  always_comb begin
    m0_hready_o = HREADY;
    m0_hrdata_o = w_m0_own ? HRDATA : 32'h0;
    m0_hresp_o  = w_m0_own && HRESP;
    if (w_m0_req && w_gnt) begin
      m0_hready_o = 1'b0;
    end else if (!w_gnt && r_m0_hold_vld && HREADY) begin
      m0_hready_o = 1'b1;
      m0_hrdata_o = r_m0_hold_data;
      m0_hresp_o  = r_m0_hold_resp;
    end

    m1_hready_o = HREADY;
    m1_hrdata_o = w_m1_own ? HRDATA : 32'h0;
    m1_hresp_o  = w_m1_own && HRESP;
    if (w_m1_req && !w_gnt) begin
      m1_hready_o = 1'b0;
    end else if (w_gnt && r_m1_hold_vld && HREADY) begin
      m1_hready_o = 1'b1;
      m1_hrdata_o = r_m1_hold_data;
      m1_hresp_o  = r_m1_hold_resp;
    end
  end

  // Grant latch and data-phase owner
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gnt_lat  <= 1'b0;
      r_wait     <= 1'b0;
      r_hmaster  <= 1'b0;
      r_dp_valid <= 1'b0;
    end else begin
      r_gnt_lat <= w_gnt;
      r_wait    <= !HREADY;
      if (HREADY) begin
        r_hmaster  <= w_gnt;
        r_dp_valid <= w_gnt_req;
      end
    end
  end

  // Starvation counter, counts accepted M1 grants while M0 waits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve <= 3'd0;
    end else if (!w_m0_req) begin
      r_starve <= 3'd0;
    end else if (HREADY && w_gnt_req) begin
      if (!w_gnt)
        r_starve <= 3'd0;
      else if (r_starve != LP_STARVE_MAX)
        r_starve <= r_starve + 3'd1;
    end
  end

  // Hold registers: park a response whose owner lost the bus; release it on regrant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_m0_hold_vld  <= 1'b0;
      r_m0_hold_data <= 32'h0;
      r_m0_hold_resp <= 1'b0;
      r_m1_hold_vld  <= 1'b0;
      r_m1_hold_data <= 32'h0;
      r_m1_hold_resp <= 1'b0;
    end else begin
      if (w_m0_req && w_gnt && w_m0_own && HREADY) begin
        r_m0_hold_vld  <= 1'b1;
        r_m0_hold_data <= HRDATA;
        r_m0_hold_resp <= HRESP;
      end else if (!w_gnt && r_m0_hold_vld && HREADY) begin
        r_m0_hold_vld  <= 1'b0;
      end
      if (w_m1_req && !w_gnt && w_m1_own && HREADY) begin
        r_m1_hold_vld  <= 1'b1;
        r_m1_hold_data <= HRDATA;
        r_m1_hold_resp <= HRESP;
      end else if (w_gnt && r_m1_hold_vld && HREADY) begin
        r_m1_hold_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kmkz_ahb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_kmkz_ahb_arbiter
//   Directed bench for kmkz_ahb_arbiter. Per-cycle vectors are held in a table
//   and followed by hand sequences for starvation, parked reads and reset.
//   Inputs change 1 ns after the rising edge. Outputs are compared 2 ns later.
// -----------------------------------------------------------------------------
module tb_kmkz_ahb_arbiter;

  logic        clk;
  logic        rst_i;
  logic [31:0] m0_haddr, m1_haddr, m1_hwdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        m1_hwrite;
  logic        m0_hready_o, m1_hready_o, m0_hresp_o, m1_hresp_o;
  logic [31:0] m0_hrdata_o, m1_hrdata_o;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        hmaster_o;

  int n_checks = 0;
  int n_errors = 0;

  kmkz_ahb_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_haddr_i(m0_haddr), .m0_htrans_i(m0_htrans), .m0_hsize_i(m0_hsize), .m0_hprot_i(m0_hprot),
    .m1_haddr_i(m1_haddr), .m1_htrans_i(m1_htrans), .m1_hsize_i(m1_hsize), .m1_hprot_i(m1_hprot),
    .m1_hwrite_i(m1_hwrite), .m1_hwdata_i(m1_hwdata),
    .m0_hready_o(m0_hready_o), .m0_hrdata_o(m0_hrdata_o), .m0_hresp_o(m0_hresp_o),
    .m1_hready_o(m1_hready_o), .m1_hrdata_o(m1_hrdata_o), .m1_hresp_o(m1_hresp_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .hmaster_o(hmaster_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_wr;
    logic [31:0] m1_wdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;
    logic        e_gnt;
    logic [31:0] e_haddr;
    logic [1:0]  e_htrans;
    logic        e_hwrite;
    logic [31:0] e_hwdata;
    logic        e_hmaster;
    logic        e_m0_rdy;
    logic [31:0] e_m0_rdata;
    logic        e_m0_resp;
    logic        e_m1_rdy;
    logic [31:0] e_m1_rdata;
    logic        e_m1_resp;
  } vec_t;

  vec_t vecs [0:16];

  // Driver tasks
  task automatic drive(input logic m0r, input logic [31:0] m0a, input logic m1r,
                       input logic [31:0] m1a, input logic m1w, input logic [31:0] m1d,
                       input logic hr, input logic [31:0] hd, input logic hs);
    m0_htrans = m0r ? 2'b10 : 2'b00;
    m0_haddr  = m0a;
    m1_htrans = m1r ? 2'b10 : 2'b00;
    m1_haddr  = m1a;
    m1_hwrite = m1w;
    m1_hwdata = m1d;
    HREADY    = hr;
    HRDATA    = hd;
    HRESP     = hs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_row(input vec_t v);
    drive(v.m0_req, v.m0_addr, v.m1_req, v.m1_addr, v.m1_wr, v.m1_wdata, v.hready, v.hrdata, v.hresp);
    #2;
    chk("haddr", HADDR, v.e_haddr);
    chk("htrans", 32'(HTRANS), 32'(v.e_htrans));
    chk("hwrite", 32'(HWRITE), 32'(v.e_hwrite));
    chk("hwdata", HWDATA, v.e_hwdata);
    chk("hmaster", 32'(hmaster_o), 32'(v.e_hmaster));
    chk("m0_hready", 32'(m0_hready_o), 32'(v.e_m0_rdy));
    chk("m0_hrdata", m0_hrdata_o, v.e_m0_rdata);
    chk("m0_hresp", 32'(m0_hresp_o), 32'(v.e_m0_resp));
    chk("m1_hready", 32'(m1_hready_o), 32'(v.e_m1_rdy));
    chk("m1_hrdata", m1_hrdata_o, v.e_m1_rdata);
    chk("m1_hresp", 32'(m1_hresp_o), 32'(v.e_m1_resp));
    if (v.e_htrans == 2'b10) begin
      chk("hsize", 32'(HSIZE), v.e_gnt ? 32'h1 : 32'h2);
      chk("hprot", 32'(HPROT), v.e_gnt ? 32'h3 : 32'h1);
    end
    tick();
  endtask

  initial begin
    // Row columns: m0 req/addr, m1 req/addr/write/wdata, HREADY/HRDATA/HRESP |
    //   expected gnt, HADDR, HTRANS, HWRITE, HWDATA, hmaster | m0 rdy/rdata/resp | m1 rdy/rdata/resp
    vecs[0]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,        1'b1, 32'hAAAA0000, 1'b0,  1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        1'b0,  1'b1, 32'h0,   1'b0,  1'b1, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h100, 1'b0, 32'h0,    1'b0, 32'h0,        1'b1, 32'h0,        1'b0,  1'b0, 32'h100,  2'b10, 1'b0, 32'h0,        1'b0,  1'b1, 32'h0,   1'b0,  1'b1, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 32'h104, 1'b0, 32'h0,    1'b0, 32'h0,        1'b1, 32'h100,      1'b0,  1'b0, 32'h104,  2'b10, 1'b0, 32'h0,        1'b0,  1'b1, 32'h100, 1'b0,  1'b1, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 32'h108, 1'b0, 32'h0,    1'b0, 32'h0,        1'b1, 32'h104,      1'b0,  1'b0, 32'h108,  2'b10, 1'b0, 32'h0,        1'b0,  1'b1, 32'h104, 1'b0,  1'b1, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,        1'b1, 32'h108,      1'b0,  1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        1'b0,  1'b1, 32'h108, 1'b0,  1'b1, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,        1'b1, 32'h55,       1'b0,  1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        1'b0,  1'b1, 32'h0,   1'b0,  1'b1, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,   1'b1, 32'h2000, 1'b1, 32'h12345678, 1'b1, 32'h0,        1'b0,  1'b1, 32'h2000, 2'b10, 1'b1, 32'h0,        1'b0,  1'b1, 32'h0,   1'b0,  1'b1, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,   1'b1, 32'h2004, 1'b1, 32'h12345678, 1'b0, 32'h0,        1'b0,  1'b1, 32'h2004, 2'b10, 1'b1, 32'h12345678, 1'b1,  1'b0, 32'h0,   1'b0,  1'b0, 32'h0, 1'b0};
    vecs[8]  = vecs[7];
    vecs[9]  = vecs[7];
    vecs[10] = '{1'b0, 32'h0,   1'b1, 32'h2004, 1'b1, 32'h12345678, 1'b1, 32'h0,        1'b0,  1'b1, 32'h2004, 2'b10, 1'b1, 32'h12345678, 1'b1,  1'b1, 32'h0,   1'b0,  1'b1, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h9ABCDEF0, 1'b1, 32'h0,        1'b0,  1'b0, 32'h0,    2'b00, 1'b0, 32'h9ABCDEF0, 1'b1,  1'b1, 32'h0,   1'b0,  1'b1, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h9ABCDEF0, 1'b1, 32'h0,        1'b0,  1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        1'b0,  1'b1, 32'h0,   1'b0,  1'b1, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,   1'b1, 32'h3000, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0,  1'b1, 32'h3000, 2'b10, 1'b0, 32'h0,        1'b0,  1'b1, 32'h0,   1'b0,  1'b1, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 32'h0,        1'b1,  1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        1'b1,  1'b0, 32'h0,   1'b0,  1'b0, 32'h0, 1'b1};
    vecs[15] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,        1'b1, 32'h0,        1'b1,  1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        1'b1,  1'b1, 32'h0,   1'b0,  1'b1, 32'h0, 1'b1};
    vecs[16] = '{1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'h0,        1'b1, 32'h0,        1'b1,  1'b0, 32'h0,    2'b00, 1'b0, 32'h0,        1'b0,  1'b1, 32'h0,   1'b0,  1'b1, 32'h0, 1'b0};

    m0_hsize = 3'b010; m0_hprot = 4'b0001;
    m1_hsize = 3'b001; m1_hprot = 4'b0011;
    rst_i = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234, 1'b1);
    #3;
    chk("rst_hmaster", 32'(hmaster_o), 32'h0);
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_m0_hrdata", m0_hrdata_o, 32'h0);
    chk("rst_m0_hresp", 32'(m0_hresp_o), 32'h0);
    chk("rst_m1_hready", 32'(m1_hready_o), 32'h1);
    @(posedge clk);
    tick();
    rst_i = 1'b0;

    // Table-driven section: streaming M0 reads, M1 write with wait states, M1 error
    for (int r = 0; r <= 16; r++) apply_row(vecs[r]);

    // Starvation: both request every cycle, grants go M1 x4 then M0
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 32'(i), 1'b0);
      #2;
      chk("starve_haddr", HADDR, (i % 5 == 4) ? 32'h1000 : 32'h2000);
      chk("starve_m0_hready", 32'(m0_hready_o), (i % 5 == 4) ? 32'h1 : 32'h0);
      chk("starve_m1_hready", 32'(m1_hready_o), (i % 5 == 4) ? 32'h0 : 32'h1);
      if (i % 5 == 0 && i > 0) chk("starve_m1_hold", m1_hrdata_o, 32'(i - 1));
      if (i % 5 == 4 && i > 4) chk("starve_m0_hold", m0_hrdata_o, 32'(i - 4));
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 32'd15, 1'b0);
    #2;
    chk("starve_tail_m1_hready", 32'(m1_hready_o), 32'h1);
    chk("starve_tail_m1_hold", m1_hrdata_o, 32'd14);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    tick();
    tick();

    // Parked M0 read: M1 takes the bus while M0 at 0x100 is in its data phase
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    tick();
    drive(1'b1, 32'h104, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    #2;
    chk("park_haddr_m1", HADDR, 32'h2000);
    chk("park_m0_hready_low", 32'(m0_hready_o), 32'h0);
    tick();
    drive(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h11111111, 1'b0);
    #2;
    chk("park_haddr_m0", HADDR, 32'h104);
    chk("park_m0_hready", 32'(m0_hready_o), 32'h1);
    chk("park_m0_hrdata", m0_hrdata_o, 32'hDEADBEEF);
    chk("park_m1_hrdata", m1_hrdata_o, 32'h11111111);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0);
    #2;
    chk("park_next_m0_hrdata", m0_hrdata_o, 32'h104);
    tick();
    tick();

    // Reset with a parked M0 response outstanding
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    tick();
    drive(1'b1, 32'h104, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    drive(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h5555, 1'b1, 32'h77, 1'b0);
    #1;
    chk("prerst_m0_hrdata", m0_hrdata_o, 32'hDEADBEEF);
    chk("prerst_hwdata", HWDATA, 32'h5555);
    rst_i = 1'b1;
    #1;
    chk("midrst_m0_hrdata", m0_hrdata_o, 32'h0);
    chk("midrst_m0_hready", 32'(m0_hready_o), 32'h1);
    chk("midrst_hmaster", 32'(hmaster_o), 32'h0);
    chk("midrst_hwdata", HWDATA, 32'h0);
    chk("midrst_m1_hrdata", m1_hrdata_o, 32'h0);
    @(posedge clk);
    tick();
    rst_i = 1'b0;
    drive(1'b1, 32'h104, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 32'h99, 1'b0);
    #2;
    chk("postrst_haddr", HADDR, 32'h2000);
    chk("postrst_m0_hready", 32'(m0_hready_o), 32'h0);
    chk("postrst_m0_hrdata", m0_hrdata_o, 32'h0);
    chk("postrst_m1_hrdata", m1_hrdata_o, 32'h0);
    tick();
    drive(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h88, 1'b0);
    #2;
    chk("postrst2_haddr", HADDR, 32'h104);
    chk("postrst2_m0_hready", 32'(m0_hready_o), 32'h1);
    chk("postrst2_m0_hrdata", m0_hrdata_o, 32'h0);
    chk("postrst2_m1_hrdata", m1_hrdata_o, 32'h88);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
